// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcode classes,
// datapath select codes and the per-class ALU operand selection used in EXEC/MEM/WB.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_R       = 4'd1,
    CLS_I_ARITH = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_AUIPC   = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_LOAD    = 4'd8,
    CLS_STORE   = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_SYSTEM  = 4'd11
  } op_class_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_ALU    = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef struct packed {
    logic       src_a;
    logic       src_b;
    logic [1:0] op;
  } alu_sel_t;

  // ALU operand/op selection established in EXEC and held through MEM and WB.
  function automatic alu_sel_t exec_alu_sel(input op_class_t cls);
    alu_sel_t s;
    s = '{src_a: 1'b0, src_b: 1'b0, op: ALU_OP_ADD};
    case (cls)
      CLS_R:       s.op = ALU_OP_FUNCT;
      CLS_I_ARITH: begin s.op = ALU_OP_FUNCT;  s.src_b = 1'b1; end
      CLS_LUI:     begin s.op = ALU_OP_PASS_B; s.src_b = 1'b1; end
      CLS_AUIPC,
      CLS_JAL:     begin s.src_a = 1'b1; s.src_b = 1'b1; end
      CLS_JALR,
      CLS_LOAD,
      CLS_STORE:   s.src_b = 1'b1;
      CLS_BRANCH:  s.op = ALU_OP_SUB;
      default:     ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass_dec.sv
// Combinational RV32I opcode -> class decoder with an illegal-opcode flag.
// Kept standalone so a pipelined decode stage can reuse it.
module multicycle_ctrl_opclass_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] op_class,
  output logic       illegal
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    op_class = CLS_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPCODE_OP:     op_class = CLS_R;
      OPCODE_OP_IMM: op_class = CLS_I_ARITH;
      OPCODE_LUI:    op_class = CLS_LUI;
      OPCODE_AUIPC:  op_class = CLS_AUIPC;
      OPCODE_JAL:    op_class = CLS_JAL;
      OPCODE_JALR:   op_class = CLS_JALR;
      OPCODE_BRANCH: op_class = CLS_BRANCH;
      OPCODE_LOAD:   op_class = CLS_LOAD;
      OPCODE_STORE:  op_class = CLS_STORE;
      OPCODE_FENCE:  op_class = CLS_FENCE;
      OPCODE_SYSTEM: op_class = CLS_SYSTEM;
      default:       illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_src,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_t     state;
  op_class_t  class_q;
  logic [3:0] dec_class_raw;
  op_class_t  dec_class;
  logic       dec_illegal;
  alu_sel_t   alu_sel;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^inst_in[31:7];

  multicycle_ctrl_opclass_dec u_dec (
    .opcode   (inst_in[6:0]),
    .op_class (dec_class_raw),
    .illegal  (dec_illegal)
  );

  assign dec_class = op_class_t'(dec_class_raw);
  assign alu_sel   = exec_alu_sel(class_q);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      class_q <= CLS_NONE;
    end else begin
      case (state)
        ST_IDLE:   state <= ST_FETCH;
        ST_FETCH:  if (mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          class_q <= dec_class;
          if (dec_illegal)                  state <= ST_TRAP;
          else if (dec_class == CLS_SYSTEM) state <= ST_HALT;
          else if (dec_class == CLS_FENCE)  state <= ST_FETCH;
          else                              state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (class_q)
            CLS_BRANCH:                        state <= ST_FETCH;
            CLS_LOAD, CLS_STORE:               state <= ST_MEM;
            CLS_NONE, CLS_FENCE, CLS_SYSTEM:   state <= ST_TRAP;
            default:                           state <= ST_WB;
          endcase
        end
        ST_MEM: if (mem_ready) state <= (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:     state <= ST_FETCH;
        default:   ;  // HALT and TRAP are left only through reset
      endcase
    end
  end

  // mem_req/mem_we/mem_addr_src depend on state and class_q only, so they stay stable
  // for the whole handshake; mem_ready and branch_taken only gate the write enables.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PC4;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_OP_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      ST_EXEC: begin
        alu_src_a = alu_sel.src_a;
        alu_src_b = alu_sel.src_b;
        alu_op    = alu_sel.op;
        if (class_q == CLS_JAL || class_q == CLS_JALR) begin
          pc_we  = 1'b1;
          pc_src = PC_SRC_ALU;
        end else if (class_q == CLS_BRANCH) begin
          pc_we  = branch_taken;
          pc_src = PC_SRC_BRANCH;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (class_q == CLS_STORE);
        alu_src_a    = alu_sel.src_a;
        alu_src_b    = alu_sel.src_b;
        alu_op       = alu_sel.op;
      end
      ST_WB: begin
        reg_we    = 1'b1;
        alu_src_a = alu_sel.src_a;
        alu_src_b = alu_sel.src_b;
        alu_op    = alu_sel.op;
        if (class_q == CLS_LOAD)                              wb_sel = WB_SEL_MEM;
        else if (class_q == CLS_JAL || class_q == CLS_JALR)  wb_sel = WB_SEL_PC4;
      end
      ST_HALT: halted  = 1'b1;
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic        retire;
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // An instruction retires on the cycle whose edge returns the FSM to FETCH.
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_DECODE: retire = !dec_illegal && (dec_class == CLS_FENCE);
      ST_EXEC:   retire = (class_q == CLS_BRANCH);
      ST_MEM:    retire = (class_q == CLS_STORE) && mem_ready;
      ST_WB:     retire = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (!(state inside {ST_IDLE, ST_HALT, ST_TRAP})) cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model pushes the expected
// per-cycle control vector; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_in = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, mem_addr_src, ir_we, pc_we;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic        alu_src_a, alu_src_b, reg_we, halted, illegal;
  logic [31:0] cycle_cnt, instret_cnt;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_in      (inst_in),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_src (mem_addr_src),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .illegal      (illegal),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    ctrl_t       ctrl;
    logic [31:0] cyc;
    logic [31:0] ret;
    int          tag;
  } exp_t;

  typedef enum int {K_R, K_I, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_FENCE, K_SYS, K_BAD} kind_e;

  localparam int T_RST = 0, T_IDLE = 1, T_FETCH = 2, T_DECODE = 3, T_EXEC = 4,
                 T_MEM = 5, T_WB = 6, T_HALT = 7, T_TRAP = 8;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  logic [31:0] cyc_m = '0;
  logic [31:0] ret_m = '0;
  ctrl_t       act;

  logic [6:0] legal_opc [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111};

  assign act = {mem_req, mem_we, mem_addr_src, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_we, wb_sel, halted, illegal};

  function automatic string phase_name(input int t);
    case (t)
      T_RST:    return "RESET";
      T_IDLE:   return "IDLE";
      T_FETCH:  return "FETCH";
      T_DECODE: return "DECODE";
      T_EXEC:   return "EXEC";
      T_MEM:    return "MEM";
      T_WB:     return "WB";
      T_HALT:   return "HALT";
      default:  return "TRAP";
    endcase
  endfunction

  function automatic kind_e kind_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1100011: return K_BR;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b0001111: return K_FENCE;
      7'b1110011: return K_SYS;
      default:    return K_BAD;
    endcase
  endfunction

  // ALU selects an instruction kind uses from EXEC through WB.
  function automatic ctrl_t alu_ctrl(input kind_e k);
    ctrl_t c;
    c = '0;
    case (k)
      K_R:           c.alu_op = 2'b10;
      K_I:           begin c.alu_op = 2'b10; c.alu_src_b = 1'b1; end
      K_LUI:         begin c.alu_op = 2'b11; c.alu_src_b = 1'b1; end
      K_AUIPC, K_JAL: begin c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; end
      K_JALR, K_LD, K_ST: c.alu_src_b = 1'b1;
      K_BR:          c.alu_op = 2'b01;
      default:       ;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input int tag, input logic [31:0] ir, input ctrl_t c, input bit counted,
                      input logic ready, input logic taken);
    exp_t e;
    @(posedge clk);
    #1;
    inst_in      = ir;
    mem_ready    = ready;
    branch_taken = taken;
    e.ctrl = c;
    e.tag  = tag;
`ifdef MC_PERF_CNT_EN
    e.cyc = cyc_m;
    e.ret = ret_m;
`else
    e.cyc = '0;
    e.ret = '0;
`endif
    sb_q.push_back(e);
    n_push++;
    if (counted) cyc_m++;
  endtask

  // Reset asserted mid-cycle (asynchronously), held n cycles, released into one IDLE cycle.
  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst   = 1'b0;
      cyc_m = '0;
      ret_m = '0;
      begin
        exp_t e;
        e.ctrl = '0; e.tag = T_RST; e.cyc = '0; e.ret = '0;
        mem_ready = rb(); branch_taken = rb();
        sb_q.push_back(e);
        n_push++;
      end
    end
    step(T_IDLE, $urandom(), '0, 1'b0, rb(), rb());
    rst = 1'b1;
  endtask

  task automatic run_inst(input logic [31:0] inst, input int fwait, input int mwait,
                          input logic taken, input bit abort_in_mem, input int hold_n);
    kind_e k;
    ctrl_t c;
    k = kind_of(inst[6:0]);
    for (int i = 0; i <= fwait; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      if (i == fwait) begin c.ir_we = 1'b1; c.pc_we = 1'b1; end
      step(T_FETCH, inst, c, 1'b1, (i == fwait), rb());
    end
    step(T_DECODE, inst, '0, 1'b1, rb(), rb());
    if (k == K_SYS || k == K_BAD) begin
      c = '0;
      if (k == K_SYS) c.halted = 1'b1;
      else            c.illegal = 1'b1;
      for (int i = 0; i < hold_n; i++)
        step((k == K_SYS) ? T_HALT : T_TRAP, inst, c, 1'b0, rb(), rb());
      return;
    end
    if (k == K_FENCE) begin ret_m++; return; end
    c = alu_ctrl(k);
    if (k == K_JAL || k == K_JALR) begin c.pc_we = 1'b1; c.pc_src = 2'b01; end
    if (k == K_BR) begin c.pc_we = taken; c.pc_src = 2'b10; end
    step(T_EXEC, inst, c, 1'b1, rb(), (k == K_BR) ? taken : rb());
    if (k == K_BR) begin ret_m++; return; end
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= mwait; i++) begin
        if (abort_in_mem && i == mwait) begin apply_reset(2); return; end
        c = alu_ctrl(k);
        c.mem_req = 1'b1;
        c.mem_addr_src = 1'b1;
        c.mem_we = (k == K_ST);
        step(T_MEM, inst, c, 1'b1, (i == mwait), rb());
      end
      if (k == K_ST) begin ret_m++; return; end
    end
    c = alu_ctrl(k);
    c.reg_we = 1'b1;
    if (k == K_LD)                     c.wb_sel = 2'b01;
    else if (k == K_JAL || k == K_JALR) c.wb_sel = 2'b10;
    step(T_WB, inst, c, 1'b1, rb(), rb());
    ret_m++;
  endtask

  task automatic run_random();
    logic [31:0] r;
    r = $urandom();
    run_inst({r[31:7], legal_opc[$urandom_range(0, 9)]}, $urandom_range(0, 3),
             $urandom_range(0, 3), rb(), 1'b0, 0);
  endtask

  // Monitor: compares every cycle for which the model queued an expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_pop++;
        check($sformatf("%s ctrl #%0d", phase_name(e.tag), n_pop), 32'(act), 32'(e.ctrl));
        check($sformatf("%s cycle_cnt #%0d", phase_name(e.tag), n_pop), cycle_cnt, e.cyc);
        check($sformatf("%s instret_cnt #%0d", phase_name(e.tag), n_pop), instret_cnt, e.ret);
      end
    end
  end

  initial begin
    apply_reset(3);
    // Directed: ADDI, LW with 2 MEM waits, BEQ taken/not, JAL, FENCE, SW, LUI, AUIPC, JALR, ADD.
    run_inst(32'h00100093, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h0000A083, 0, 2, 1'b0, 1'b0, 0);
    run_inst(32'h00000063, 0, 0, 1'b1, 1'b0, 0);
    run_inst(32'h00000063, 1, 0, 1'b0, 1'b0, 0);
    run_inst(32'h0080006F, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h0000000F, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h0020A023, 2, 1, 1'b0, 1'b0, 0);
    run_inst(32'h123450B7, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h00001097, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h000080E7, 1, 0, 1'b0, 1'b0, 0);
    run_inst(32'h002081B3, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h0000007F, 0, 0, 1'b0, 1'b0, 100);

    apply_reset(2);
    repeat (30) run_random();
    run_inst(32'h00000073, $urandom_range(0, 2), 0, 1'b0, 1'b0, 20);

    apply_reset(2);
    repeat (20) run_random();
    run_inst(32'h0000A083, 1, 3, 1'b0, 1'b1, 0);
    run_inst(32'h00100093, 0, 0, 1'b0, 1'b0, 0);
    run_inst(32'h00100073, 0, 0, 1'b0, 1'b0, 5);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    check("monitor pops", 32'(n_pop), 32'(n_push));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
